// File: rtl/noc_pwr_idle_initiator.sv
// Four-phase idle/fence initiator toward the NoC power-disconnect unit.
// Optional handshake-timeout watchdog enabled by NOC_PWR_IDLE_TIMEOUT_EN.
module noc_pwr_idle_initiator #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fence_req,
    output logic                 o_fence_done,
    output logic                 o_pwr_idle_req,
    input  logic                 i_pwr_idle_ack,
    input  logic                 i_pwr_idle_val,
    input  logic [TIMEOUT_W-1:0] i_timeout_cycles,
    input  logic                 i_err_clr,
    output logic                 o_timeout_err,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REQ    = 2'd1,
        FENCED = 2'd2,
        REL    = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   req_q, done_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:    if (i_fence_req) state_nxt = REQ;
            // req is never withdrawn before ack, even when the fence is dropped
            REQ: begin
                if (i_fence_req && i_pwr_idle_ack && i_pwr_idle_val) state_nxt = FENCED;
                else if (!i_fence_req && i_pwr_idle_ack)             state_nxt = REL;
            end
            FENCED: if (!i_fence_req) state_nxt = REL;
            REL:    if (!i_pwr_idle_ack && !i_pwr_idle_val) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Outputs are flopped from the next state so they change on the same edge as o_state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= RUN;
            req_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            req_q  <= (state_nxt == REQ) || (state_nxt == FENCED);
            done_q <= (state_nxt == FENCED);
        end
    end

    assign o_pwr_idle_req = req_q;
    assign o_fence_done   = done_q;
    assign o_state        = state;

`ifdef NOC_PWR_IDLE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 err_q;
    logic                 in_hs, entering_hs, tmo_hit;

    assign in_hs       = (state == REQ) || (state == REL);
    assign entering_hs = (state_nxt != state) && ((state_nxt == REQ) || (state_nxt == REL));
    assign tmo_hit     = in_hs && (i_timeout_cycles != '0) && (tmo_cnt == i_timeout_cycles);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (entering_hs)                  tmo_cnt <= '0;
            else if (in_hs && (~tmo_cnt != '0)) tmo_cnt <= tmo_cnt + 1'b1;
            // set has priority over clear
            if (tmo_hit)        err_q <= 1'b1;
            else if (i_err_clr) err_q <= 1'b0;
        end
    end

    assign o_timeout_err = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^{i_timeout_cycles, i_err_clr};
    assign o_timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_noc_pwr_idle_initiator.sv
// Directed bench for noc_pwr_idle_initiator: vector table plus multi-cycle corner sequences.
module tb_noc_pwr_idle_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        fence_req, ack, val, err_clr;
    logic [15:0] tmo_cycles;
    logic        fence_done, idle_req, tmo_err;
    logic [1:0]  state;

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    noc_pwr_idle_initiator #(.TIMEOUT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_fence_req(fence_req), .o_fence_done(fence_done),
        .o_pwr_idle_req(idle_req), .i_pwr_idle_ack(ack), .i_pwr_idle_val(val),
        .i_timeout_cycles(tmo_cycles), .i_err_clr(err_clr), .o_timeout_err(tmo_err),
        .o_state(state)
    );

    typedef struct {
        logic       f, a, v;
        logic       req, done;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one clock edge, sample 1 time unit after it
    task automatic step(input logic f, input logic a, input logic v);
        fence_req = f; ack = a; val = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{0,0,0, 0,0,0};
        tbl[1]  = '{1,0,0, 1,0,1};
        tbl[2]  = '{1,1,0, 1,0,1};  // ack without val is not completion
        tbl[3]  = '{1,0,1, 1,0,1};
        tbl[4]  = '{1,1,1, 1,1,2};
        tbl[5]  = '{1,1,1, 1,1,2};
        tbl[6]  = '{0,1,1, 0,0,3};
        tbl[7]  = '{1,1,1, 0,0,3};  // fence ignored in REL
        tbl[8]  = '{1,0,1, 0,0,3};
        tbl[9]  = '{1,1,0, 0,0,3};
        tbl[10] = '{1,0,0, 0,0,0};
        tbl[11] = '{1,0,0, 1,0,1};  // pending fence re-requests
        tbl[12] = '{0,0,0, 1,0,1};
        tbl[13] = '{0,0,1, 1,0,1};
        tbl[14] = '{0,1,1, 0,0,3};  // fence dropped: ack ends in REL, no done
        tbl[15] = '{0,0,0, 0,0,0};
        tbl[16] = '{0,0,0, 0,0,0};

        rst = 1'b1; fence_req = 0; ack = 0; val = 0; err_clr = 0; tmo_cycles = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req",   32'(idle_req),   0);
        chk("reset_done",  32'(fence_done), 0);
        chk("reset_err",   32'(tmo_err),    0);
        chk("reset_state", 32'(state),      0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].f, tbl[i].a, tbl[i].v);
            chk($sformatf("vec%0d_req", i),   32'(idle_req),   32'(tbl[i].req));
            chk($sformatf("vec%0d_done", i),  32'(fence_done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_state", i), 32'(state),      32'(tbl[i].st));
        end

        // Fence: req at cycle 0, ack&val at cycle 5
        for (int c = 0; c <= 5; c++) begin
            step(1, c == 5, c == 5);
            chk($sformatf("fence_c%0d_req", c),  32'(idle_req),   1);
            chk($sformatf("fence_c%0d_done", c), 32'(fence_done), 32'(c == 5));
        end
        chk("fence_state", 32'(state), 2);

        // Release: drop fence, ack&val drop three cycles later
        step(0, 1, 1);
        chk("rel_req",  32'(idle_req),   0);
        chk("rel_done", 32'(fence_done), 0);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("rel_wait_state", 32'(state), 3);
        step(0, 0, 0);
        chk("rel_run_state", 32'(state), 0);

        // Abort: fence pulsed two cycles, ack at cycle 8
        for (int c = 0; c <= 9; c++) begin
            step(c < 2, c == 8, 1'b0);
            chk($sformatf("abort_c%0d_done", c), 32'(fence_done), 0);
            chk($sformatf("abort_c%0d_req", c),  32'(idle_req),   32'(c < 8));
            chk($sformatf("abort_c%0d_state", c), 32'(state),
                (c < 8) ? 32'd1 : (c == 8) ? 32'd3 : 32'd0);
        end

        // Partial response: ack without val for 20 cycles
        step(1, 0, 0);
        for (int c = 0; c < 20; c++) begin
            step(1, 1, 0);
            chk($sformatf("partial_c%0d_state", c), 32'(state),      1);
            chk($sformatf("partial_c%0d_done", c),  32'(fence_done), 0);
        end
        step(1, 1, 1);
        chk("partial_fenced", 32'(state), 2);
        step(0, 1, 1);
        step(0, 0, 0);
        chk("partial_run", 32'(state), 0);

        // Asynchronous reset mid-handshake
        step(1, 0, 0);
        chk("rst_pre_req", 32'(idle_req), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_req",   32'(idle_req), 0);
        chk("rst_async_state", 32'(state),    0);
        @(negedge clk);
        rst = 1'b0; fence_req = 0;
        step(0, 0, 0);
        chk("rst_after_state", 32'(state), 0);

`ifdef NOC_PWR_IDLE_TIMEOUT_EN
        tmo_cycles = 16'd10;
        step(1, 0, 0);
        for (int c = 0; c < 5; c++) step(1, 0, 0);
        chk("tmo_early", 32'(tmo_err), 0);
        for (int c = 0; c < 7; c++) step(1, 0, 0);
        chk("tmo_set", 32'(tmo_err), 1);
        step(1, 1, 1);
        chk("tmo_late_fence", 32'(state),   2);
        chk("tmo_sticky",     32'(tmo_err), 1);
        err_clr = 1'b1;
        step(1, 1, 1);
        err_clr = 1'b0;
        chk("tmo_clear", 32'(tmo_err), 0);
        step(0, 1, 1);
        step(0, 0, 0);
        tmo_cycles = 16'd0;
        step(1, 0, 0);
        for (int c = 0; c < 30; c++) step(1, 0, 0);
        chk("tmo_disabled", 32'(tmo_err), 0);
        step(1, 1, 1);
        step(0, 1, 1);
        step(0, 0, 0);
`else
        tmo_cycles = 16'd3;
        step(1, 0, 0);
        for (int c = 0; c < 10; c++) step(1, 0, 0);
        chk("tmo_off_err", 32'(tmo_err), 0);
        step(1, 1, 1);
        step(0, 1, 1);
        step(0, 0, 0);
`endif
        chk("final_state", 32'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
